pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL provide, one port per line, as follows.
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- xm_dREN  in  1  EX/MEM stage holds a load
- xm_dWEN  in  1  EX/MEM stage holds a store
- dx_dREN  in  1  ID/EX stage holds a load
- dx_wsel  in  5  ID/EX destination register
- fd_rs  in  5  IF/ID source register rs
- fd_rt  in  5  IF/ID source register rt
- branch_taken  in  1  branch or jump resolved taken in EX
- mw_halt  in  1  MEM/WB stage holds halt
- pc_EN  out  1  PC update enable
- stage_EN  out  4  register enables: bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB
- stage_flush  out  4  register clears, same bit order; a flush overrides EN in the register
- halted  out  1  core stopped, registered
- stall_cycles  out  32  frozen-cycle count (PERF_CNT_EN only)
- flush_events  out  32  branch-flush count (PERF_CNT_EN only)

Function
REQ-002 SHALL implement FSM RUN, MEMWAIT, HALT; the state is registered; the enable and flush outputs are combinational from the state and the inputs.
REQ-003 SHALL define the data request dreq = xm_dREN | xm_dWEN.
REQ-004 SHALL, in RUN, apply conditions in the priority order below (first match wins); the default is pc_EN=1, stage_EN=4'b1111, stage_flush=0.
- mw_halt: all EN=0; next state HALT.
- dreq & !dhit: all EN=0, no flush; next state MEMWAIT.
- branch_taken: pc_EN=1; stage_flush[0]=1 and stage_flush[1]=1; other stages enabled.
- Load-use: dx_dREN & dx_wsel!=0 & (dx_wsel==fd_rs | dx_wsel==fd_rt) gives pc_EN=0, stage_EN[0]=0, stage_flush[1]=1, and stage_EN[3:2]=2'b11.
- !ihit: same as load-use (freeze PC and IF/ID, bubble into ID/EX).
REQ-005 SHALL, in MEMWAIT, behave as follows.
- While dhit=0: all EN=0, no flush.
- On dhit=1: evaluate the RUN rules excluding the dreq row; next state RUN.
REQ-006 SHALL, in HALT, hold all EN=0 and all flush=0, set halted=1 from the next edge, and leave HALT only by reset.
REQ-007 SHALL resolve simultaneous branch_taken and load-use in favour of the branch, because the dependent instruction is squashed.
REQ-008 SHALL advance the pipeline with no stall cycle when dreq and dhit are both high in the same RUN cycle.

Reset
REQ-009 SHALL, while nRST=0, force state=RUN, halted=0 and counters=0; outputs SHALL take their RUN defaults for the current inputs.
REQ-010 SHALL abandon a pending MEMWAIT when nRST asserts mid-wait; no wait state is retained after reset.

Configuration
REQ-011 SHALL gate the counters with macro PIPELINE_CTRL_PERF_CNT_EN.
- Defined: stall_cycles increments on every cycle with pc_EN=0 outside HALT; flush_events increments on every branch flush; both saturate at 32'hFFFFFFFF.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Structure
REQ-012 SHALL declare the state enum pctrl_state_t and the stage-bit index constants (FD=0, DX=1, XM=2, MW=3) in mux_types_pkg.
REQ-013 SHALL place the combinational load-use compare in sub-module hazard_detect, instantiated once.

Verification
REQ-014 SHALL cover the following directed scenarios.
- Load-use: dx_dREN=1, dx_wsel=5, fd_rs=5, ihit=1 -> pc_EN=0, stage_EN=4'b1100, stage_flush=4'b0010 for one cycle.
- Data wait: xm_dREN=1, dhit low for 3 cycles then high -> stage_EN=0 for 3 cycles, then 4'b1111; state returns to RUN; stall_cycles=3 with macro.
- Branch: branch_taken=1 and ihit=0 -> pc_EN=1, stage_flush=4'b0011; flush_events +1.
- Halt: mw_halt=1 -> all EN=0 that cycle, halted=1 at the next edge; stays 1 for 10 cycles with ihit and dhit toggling.
- Reset in MEMWAIT: nRST low during cycle 2 of the wait -> halted=0, state RUN, counters 0 immediately.
- Zero register: dx_dREN=1, dx_wsel=0, fd_rt=0 -> no stall, stage_EN=4'b1111.

Source files
------------

// File: rtl/mux_types_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and the
// bit positions of the four pipeline registers in stage_EN / stage_flush.
package mux_types_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } pctrl_state_t;

    localparam int FD = 0;
    localparam int DX = 1;
    localparam int XM = 2;
    localparam int MW = 3;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: the ID/EX load writes a register the IF/ID instruction reads.
// Register 0 is hard-wired, so a write to it never creates a dependency.
module hazard_detect (
    input  logic       dx_dREN,
    input  logic [4:0] dx_wsel,
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    output logic       load_use
);

    logic w_nonzero;
    logic w_match;

    assign w_nonzero = (dx_wsel != 5'd0);
    assign w_match   = (dx_wsel == fd_rs) || (dx_wsel == fd_rt);
    assign load_use  = dx_dREN && w_nonzero && w_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush controller (RUN / MEMWAIT / HALT).
// Define PIPELINE_CTRL_PERF_CNT_EN to build the stall and branch-flush counters.
module pipeline_ctrl
    import mux_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        xm_dREN,
    input  logic        xm_dWEN,
    input  logic        dx_dREN,
    input  logic [4:0]  dx_wsel,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic        branch_taken,
    input  logic        mw_halt,
    output logic        pc_EN,
    output logic [3:0]  stage_EN,
    output logic [3:0]  stage_flush,
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    pctrl_state_t r_state;
    pctrl_state_t w_next;
    logic         w_dreq;
    logic         w_load_use;
    logic         w_flush_evt;

    assign w_dreq = xm_dREN | xm_dWEN;

    hazard_detect u_hazard (
        .dx_dREN  (dx_dREN),
        .dx_wsel  (dx_wsel),
        .fd_rs    (fd_rs),
        .fd_rt    (fd_rt),
        .load_use (w_load_use)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= RUN;
        else       r_state <= w_next;
    end

    // halted comes straight off the state flop, so it rises at the edge entering HALT.
    assign halted = (r_state == HALT);

    always_comb begin
        w_next      = r_state;
        pc_EN       = 1'b1;
        stage_EN    = 4'b1111;
        stage_flush = 4'b0000;
        w_flush_evt = 1'b0;
        if ((r_state == HALT) || (r_state == MEMWAIT && !dhit) || (r_state != RUN && r_state != MEMWAIT)) begin
            pc_EN    = 1'b0;
            stage_EN = 4'b0000;
        end else begin
            if (r_state == MEMWAIT) w_next = RUN;
            // The dreq row only applies in RUN; in MEMWAIT dhit is known high here.
            if (mw_halt) begin
                pc_EN    = 1'b0;
                stage_EN = 4'b0000;
                w_next   = HALT;
            end else if (r_state == RUN && w_dreq && !dhit) begin
                pc_EN    = 1'b0;
                stage_EN = 4'b0000;
                w_next   = MEMWAIT;
            end else if (branch_taken) begin
                stage_flush[FD] = 1'b1;
                stage_flush[DX] = 1'b1;
                w_flush_evt     = 1'b1;
            end else if (w_load_use || !ihit) begin
                pc_EN           = 1'b0;
                stage_EN[FD]    = 1'b0;
                stage_EN[DX]    = 1'b0;
                stage_flush[DX] = 1'b1;
            end
        end
    end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!pc_EN && r_state != HALT && r_stall_cycles != CNT_MAX)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_flush_evt && r_flush_events != CNT_MAX)
                r_flush_events <= r_flush_events + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; counter expectations follow PIPELINE_CTRL_PERF_CNT_EN.
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, xm_dREN, xm_dWEN, dx_dREN;
    logic [4:0]  dx_wsel, fd_rs, fd_rt;
    logic        branch_taken, mw_halt;
    logic        pc_EN;
    logic [3:0]  stage_EN, stage_flush;
    logic        halted;
    logic [31:0] stall_cycles, flush_events;

    int vecs = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    pipeline_ctrl dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .xm_dREN      (xm_dREN),
        .xm_dWEN      (xm_dWEN),
        .dx_dREN      (dx_dREN),
        .dx_wsel      (dx_wsel),
        .fd_rs        (fd_rs),
        .fd_rt        (fd_rt),
        .branch_taken (branch_taken),
        .mw_halt      (mw_halt),
        .pc_EN        (pc_EN),
        .stage_EN     (stage_EN),
        .stage_flush  (stage_flush),
        .halted       (halted),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    function automatic logic [31:0] cnt(input int v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; xm_dREN = 1'b0; xm_dWEN = 1'b0;
        dx_dREN = 1'b0; dx_wsel = 5'd0; fd_rs = 5'd0; fd_rt = 5'd0;
        branch_taken = 1'b0; mw_halt = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks sit on the falling edge.
    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        idle();
        nRST = 1'b0;
        step();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        nRST = 1'b0;
        #3;
        vecs++;
        if ({pc_EN, stage_EN, stage_flush, halted} !== {1'b1, 4'b1111, 4'b0000, 1'b0}) begin
            errs++; $display("FAIL reset_outputs got pc=%b en=%b fl=%b h=%b want 1 1111 0000 0", pc_EN, stage_EN, stage_flush, halted);
        end
        vecs++;
        if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
            errs++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cycles, flush_events);
        end
        step();
        nRST = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        dx_dREN = 1'b1; dx_wsel = 5'd5; fd_rs = 5'd5;
        sample();
        vecs++;
        if ({pc_EN, stage_EN, stage_flush} !== {1'b0, 4'b1100, 4'b0010}) begin
            errs++; $display("FAIL load_use_rs got pc=%b en=%b fl=%b want 0 1100 0010", pc_EN, stage_EN, stage_flush);
        end
        step();
        idle();
        sample();
        vecs++;
        if ({pc_EN, stage_EN, stage_flush} !== {1'b1, 4'b1111, 4'b0000}) begin
            errs++; $display("FAIL load_use_release got pc=%b en=%b fl=%b want 1 1111 0000", pc_EN, stage_EN, stage_flush);
        end
        vecs++;
        if (stall_cycles !== cnt(1)) begin
            errs++; $display("FAIL load_use_stallcnt got %0d want %0d", stall_cycles, cnt(1));
        end
        dx_dREN = 1'b1; dx_wsel = 5'd7; fd_rt = 5'd7; fd_rs = 5'd3;
        sample();
        vecs++;
        if ({pc_EN, stage_EN, stage_flush} !== {1'b0, 4'b1100, 4'b0010}) begin
            errs++; $display("FAIL load_use_rt got pc=%b en=%b fl=%b want 0 1100 0010", pc_EN, stage_EN, stage_flush);
        end
        idle();
        ihit = 1'b0;
        sample();
        vecs++;
        if ({pc_EN, stage_EN, stage_flush} !== {1'b0, 4'b1100, 4'b0010}) begin
            errs++; $display("FAIL ihit_miss got pc=%b en=%b fl=%b want 0 1100 0010", pc_EN, stage_EN, stage_flush);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        dx_dREN = 1'b1; dx_wsel = 5'd0; fd_rt = 5'd0; fd_rs = 5'd0;
        sample();
        vecs++;
        if ({pc_EN, stage_EN, stage_flush} !== {1'b1, 4'b1111, 4'b0000}) begin
            errs++; $display("FAIL zero_reg got pc=%b en=%b fl=%b want 1 1111 0000", pc_EN, stage_EN, stage_flush);
        end
        dx_wsel = 5'd9; fd_rs = 5'd8; fd_rt = 5'd10;
        sample();
        vecs++;
        if ({pc_EN, stage_EN} !== {1'b1, 4'b1111}) begin
            errs++; $display("FAIL no_match got pc=%b en=%b want 1 1111", pc_EN, stage_EN);
        end
    endtask

    task automatic test_branch();
        do_reset();
        branch_taken = 1'b1; ihit = 1'b0;
        sample();
        vecs++;
        if ({pc_EN, stage_flush} !== {1'b1, 4'b0011}) begin
            errs++; $display("FAIL branch got pc=%b fl=%b want 1 0011", pc_EN, stage_flush);
        end
        step();
        branch_taken = 1'b1; ihit = 1'b1; dx_dREN = 1'b1; dx_wsel = 5'd5; fd_rs = 5'd5;
        sample();
        vecs++;
        if ({pc_EN, stage_flush} !== {1'b1, 4'b0011}) begin
            errs++; $display("FAIL branch_over_loaduse got pc=%b fl=%b want 1 0011", pc_EN, stage_flush);
        end
        step();
        idle();
        sample();
        vecs++;
        if (flush_events !== cnt(2) || stall_cycles !== cnt(0)) begin
            errs++; $display("FAIL branch_counts got flush=%0d stall=%0d want %0d %0d", flush_events, stall_cycles, cnt(2), cnt(0));
        end
    endtask

    task automatic test_data_wait();
        do_reset();
        xm_dREN = 1'b1; dhit = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            vecs++;
            if ({pc_EN, stage_EN, stage_flush} !== {1'b0, 4'b0000, 4'b0000}) begin
                errs++; $display("FAIL dwait_cycle%0d got pc=%b en=%b fl=%b want 0 0000 0000", c, pc_EN, stage_EN, stage_flush);
            end
            step();
        end
        dhit = 1'b1;
        sample();
        vecs++;
        if ({pc_EN, stage_EN} !== {1'b1, 4'b1111}) begin
            errs++; $display("FAIL dwait_done got pc=%b en=%b want 1 1111", pc_EN, stage_EN);
        end
        vecs++;
        if (stall_cycles !== cnt(3)) begin
            errs++; $display("FAIL dwait_stallcnt got %0d want %0d", stall_cycles, cnt(3));
        end
        step();
        idle();
        sample();
        vecs++;
        if ({pc_EN, stage_EN} !== {1'b1, 4'b1111}) begin
            errs++; $display("FAIL dwait_back_in_run got pc=%b en=%b want 1 1111", pc_EN, stage_EN);
        end
        // Request and completion in the same cycle must not stall.
        xm_dWEN = 1'b1; dhit = 1'b1;
        sample();
        vecs++;
        if ({pc_EN, stage_EN} !== {1'b1, 4'b1111}) begin
            errs++; $display("FAIL dreq_dhit_same got pc=%b en=%b want 1 1111", pc_EN, stage_EN);
        end
        step();
        idle();
        sample();
        vecs++;
        if ({pc_EN, stage_EN} !== {1'b1, 4'b1111} || stall_cycles !== cnt(3)) begin
            errs++; $display("FAIL dreq_dhit_next got pc=%b en=%b stall=%0d want 1 1111 %0d", pc_EN, stage_EN, stall_cycles, cnt(3));
        end
    endtask

    task automatic test_reset_memwait();
        do_reset();
        xm_dREN = 1'b1; dhit = 1'b0;
        step();
        step();
        xm_dREN = 1'b0;
        nRST = 1'b0;
        #1;
        vecs++;
        if ({pc_EN, stage_EN, halted} !== {1'b1, 4'b1111, 1'b0}) begin
            errs++; $display("FAIL reset_in_wait got pc=%b en=%b h=%b want 1 1111 0", pc_EN, stage_EN, halted);
        end
        vecs++;
        if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
            errs++; $display("FAIL reset_in_wait_cnt got %0d/%0d want 0/0", stall_cycles, flush_events);
        end
        step();
        nRST = 1'b1;
        sample();
        vecs++;
        if ({pc_EN, stage_EN} !== {1'b1, 4'b1111}) begin
            errs++; $display("FAIL after_wait_reset got pc=%b en=%b want 1 1111", pc_EN, stage_EN);
        end
    endtask

    task automatic test_halt();
        do_reset();
        mw_halt = 1'b1;
        sample();
        vecs++;
        if ({pc_EN, stage_EN, halted} !== {1'b0, 4'b0000, 1'b0}) begin
            errs++; $display("FAIL halt_entry got pc=%b en=%b h=%b want 0 0000 0", pc_EN, stage_EN, halted);
        end
        step();
        mw_halt = 1'b0;
        for (int c = 0; c < 10; c++) begin
            ihit = c[0]; dhit = ~c[0]; xm_dREN = 1'b1; branch_taken = c[1];
            sample();
            vecs++;
            if ({halted, pc_EN, stage_EN, stage_flush} !== {1'b1, 1'b0, 4'b0000, 4'b0000}) begin
                errs++; $display("FAIL halt_hold%0d got h=%b pc=%b en=%b fl=%b want 1 0 0000 0000", c, halted, pc_EN, stage_EN, stage_flush);
            end
            step();
        end
        vecs++;
        if (stall_cycles !== cnt(1) || flush_events !== cnt(0)) begin
            errs++; $display("FAIL halt_counts got stall=%0d flush=%0d want %0d %0d", stall_cycles, flush_events, cnt(1), cnt(0));
        end
        do_reset();
        sample();
        vecs++;
        if ({halted, pc_EN, stage_EN} !== {1'b0, 1'b1, 4'b1111}) begin
            errs++; $display("FAIL halt_reset got h=%b pc=%b en=%b want 0 1 1111", halted, pc_EN, stage_EN);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_data_wait();
        test_reset_memwait();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
